// File: rtl/dp_geno_dispatcher_i_pkg.sv
// Shared definitions for the genotyping job dispatcher: default field widths,
// descriptor packing order and the number of DP cores served.
`ifndef GENO_SRAM_WORD_AMOUNT
// Fallback used only when the shared defines file is not part of the compile.
`define GENO_SRAM_WORD_AMOUNT 64
`endif

package dp_geno_dispatcher_i_pkg;

  localparam int NUM_DP      = 4;
  localparam int DP_PTR_W    = 2;
  localparam int GENO_ADDR_W = 16;
  localparam int GENO_LEN_W  = 10;
  localparam int GENO_CNT_W  = 16;
  localparam int GENO_ID_W   = $clog2(`GENO_SRAM_WORD_AMOUNT);

  // Descriptor layout, MSB first: {read_addr, hap_addr, read_len, hap_len, address_ID}
  function automatic int geno_job_width(input int addr_w, input int len_w, input int id_w);
    return 2 * addr_w + 2 * len_w + id_w;
  endfunction

  localparam int GENO_JOB_W = geno_job_width(GENO_ADDR_W, GENO_LEN_W, GENO_ID_W);

  typedef logic [DP_PTR_W-1:0] dp_ptr_t;

endpackage

// File: rtl/dp_geno_dispatcher_i_geno_job_fifo2.sv
// Generic 2-entry valid/ready FIFO with synchronous flush. Registered storage
// only, so nothing on the write side reaches the read side combinationally.
module geno_job_fifo2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] entry0_p0;
  logic [WIDTH-1:0] entry1_p0;
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       cnt;
  logic             push;
  logic             pop;

  // Flush blocks acceptance in its own cycle and wins over pop.
  assign in_ready  = (cnt != 2'd2) && !flush;
  assign out_valid = (cnt != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready && !flush;
  assign out_data  = rd_ptr ? entry1_p0 : entry0_p0;
  assign count     = cnt;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Descriptor storage; cleared on reset so the head reads 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry0_p0 <= '0;
      entry1_p0 <= '0;
    end else if (push) begin
      if (wr_ptr) entry1_p0 <= in_data;
      else        entry0_p0 <= in_data;
    end
  end

endmodule

// File: rtl/dp_geno_dispatcher_i.sv
// Input-side dispatcher for the genotyping path: buffers Pair-HMM job
// descriptors in a 2-entry FIFO and issues them to DP0..DP3 in strict rotation
// so the output collector can return scores in issue order.
module dp_geno_dispatcher_i
  import dp_geno_dispatcher_i_pkg::*;
#(
  parameter int ID_W   = GENO_ID_W,
  parameter int ADDR_W = GENO_ADDR_W,
  parameter int LEN_W  = GENO_LEN_W,
  parameter int CNT_W  = GENO_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_flush,
  input  logic              i_geno_valid,
  output logic              o_geno_ready,
  input  logic [ADDR_W-1:0] i_geno_read_addr,
  input  logic [ADDR_W-1:0] i_geno_hap_addr,
  input  logic [LEN_W-1:0]  i_geno_read_len,
  input  logic [LEN_W-1:0]  i_geno_hap_len,
  input  logic [ID_W-1:0]   i_geno_address_ID,
  output logic              DP0_i_valid,
  input  logic              DP0_o_ready,
  output logic [ADDR_W-1:0] DP0_i_read_addr,
  output logic [ADDR_W-1:0] DP0_i_hap_addr,
  output logic [LEN_W-1:0]  DP0_i_read_len,
  output logic [LEN_W-1:0]  DP0_i_hap_len,
  output logic [ID_W-1:0]   DP0_i_geno_address_ID,
  output logic              DP1_i_valid,
  input  logic              DP1_o_ready,
  output logic [ADDR_W-1:0] DP1_i_read_addr,
  output logic [ADDR_W-1:0] DP1_i_hap_addr,
  output logic [LEN_W-1:0]  DP1_i_read_len,
  output logic [LEN_W-1:0]  DP1_i_hap_len,
  output logic [ID_W-1:0]   DP1_i_geno_address_ID,
  output logic              DP2_i_valid,
  input  logic              DP2_o_ready,
  output logic [ADDR_W-1:0] DP2_i_read_addr,
  output logic [ADDR_W-1:0] DP2_i_hap_addr,
  output logic [LEN_W-1:0]  DP2_i_read_len,
  output logic [LEN_W-1:0]  DP2_i_hap_len,
  output logic [ID_W-1:0]   DP2_i_geno_address_ID,
  output logic              DP3_i_valid,
  input  logic              DP3_o_ready,
  output logic [ADDR_W-1:0] DP3_i_read_addr,
  output logic [ADDR_W-1:0] DP3_i_hap_addr,
  output logic [LEN_W-1:0]  DP3_i_read_len,
  output logic [LEN_W-1:0]  DP3_i_hap_len,
  output logic [ID_W-1:0]   DP3_i_geno_address_ID,
  output logic              o_busy,
  output logic [CNT_W-1:0]  o_dispatch_count,
  output logic              o_len_err
);

  localparam int JOB_W = geno_job_width(ADDR_W, LEN_W, ID_W);

  logic [JOB_W-1:0]  job_in;
  logic [JOB_W-1:0]  head_p0;
  logic              vld_p0;
  logic              head_ready;
  logic [1:0]        fifo_count;
  logic              push;
  logic              pop;
  logic              len_zero;
  dp_ptr_t           dp_ptr;
  logic [CNT_W-1:0]  dispatch_cnt;
  logic              len_err;

  logic [ADDR_W-1:0] head_read_addr;
  logic [ADDR_W-1:0] head_hap_addr;
  logic [LEN_W-1:0]  head_read_len;
  logic [LEN_W-1:0]  head_hap_len;
  logic [ID_W-1:0]   head_id;

  assign job_in = {i_geno_read_addr, i_geno_hap_addr, i_geno_read_len,
                   i_geno_hap_len, i_geno_address_ID};

  // ---- stage p0: descriptor buffer between scheduler and cores ----
  geno_job_fifo2 #(
    .WIDTH (JOB_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (i_flush),
    .in_valid  (i_geno_valid),
    .in_ready  (o_geno_ready),
    .in_data   (job_in),
    .out_valid (vld_p0),
    .out_ready (head_ready),
    .out_data  (head_p0),
    .count     (fifo_count)
  );

  assign {head_read_addr, head_hap_addr, head_read_len, head_hap_len, head_id} = head_p0;

  assign push     = i_geno_valid && o_geno_ready;
  assign pop      = vld_p0 && head_ready && !i_flush;
  assign len_zero = (i_geno_read_len == '0) || (i_geno_hap_len == '0);
  assign o_busy   = (fifo_count != 2'd0);

  // Only the core under the pointer can accept; other cores' ready is ignored.
  always_comb begin
    head_ready = 1'b0;
    case (dp_ptr)
      2'd0:    head_ready = DP0_o_ready;
      2'd1:    head_ready = DP1_o_ready;
      2'd2:    head_ready = DP2_o_ready;
      default: head_ready = DP3_o_ready;
    endcase
  end

  // Round-robin pointer; advances only on an accepted dispatch, never skips.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       dp_ptr <= '0;
    else if (i_flush) dp_ptr <= '0;
    else if (pop)     dp_ptr <= dp_ptr + 2'd1;
  end

  // Dispatched-job counter, survives flush and wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   dispatch_cnt <= '0;
    else if (pop) dispatch_cnt <= dispatch_cnt + 1'b1;
  end

  // Sticky zero-length flag; the offending job is still forwarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 len_err <= 1'b0;
    else if (push && len_zero) len_err <= 1'b1;
  end

  assign o_dispatch_count = dispatch_cnt;
  assign o_len_err        = len_err;

  // ---- fan-out: one valid under the pointer, payload shared from the head ----
  assign DP0_i_valid = vld_p0 && (dp_ptr == 2'd0);
  assign DP1_i_valid = vld_p0 && (dp_ptr == 2'd1);
  assign DP2_i_valid = vld_p0 && (dp_ptr == 2'd2);
  assign DP3_i_valid = vld_p0 && (dp_ptr == 2'd3);

  assign DP0_i_read_addr       = head_read_addr;
  assign DP0_i_hap_addr        = head_hap_addr;
  assign DP0_i_read_len        = head_read_len;
  assign DP0_i_hap_len         = head_hap_len;
  assign DP0_i_geno_address_ID = head_id;

  assign DP1_i_read_addr       = head_read_addr;
  assign DP1_i_hap_addr        = head_hap_addr;
  assign DP1_i_read_len        = head_read_len;
  assign DP1_i_hap_len         = head_hap_len;
  assign DP1_i_geno_address_ID = head_id;

  assign DP2_i_read_addr       = head_read_addr;
  assign DP2_i_hap_addr        = head_hap_addr;
  assign DP2_i_read_len        = head_read_len;
  assign DP2_i_hap_len         = head_hap_len;
  assign DP2_i_geno_address_ID = head_id;

  assign DP3_i_read_addr       = head_read_addr;
  assign DP3_i_hap_addr        = head_hap_addr;
  assign DP3_i_read_len        = head_read_len;
  assign DP3_i_hap_len         = head_hap_len;
  assign DP3_i_geno_address_ID = head_id;

endmodule
